// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, signed or unsigned,
// quotient or remainder selectable per request, abortable by flush or by request drop.
package div_iter_pkg;
  localparam int unsigned DW = 32;

  // Request payload from the execute stage.
  typedef struct packed {
    logic          req_valid;
    logic          use_mod;
    logic          is_unsigned;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
  } req_t;

  // Response payload back to the execute stage.
  typedef struct packed {
    logic [DW-1:0] result;
    logic          ok;
  } rsp_t;
endpackage

module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [66:0] es_to_div_bus,
  input  logic        flush_ES,
  output logic [32:0] div_to_es_bus
);

  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  req_t          req;
  rsp_t          rsp;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] rem, rem_n, quo, quo_n, dvs, dvs_n, res, res_n;
  logic          mod_q, mod_n, qneg, qneg_n, rneg, rneg_n, ok, ok_n;

  logic [DW-1:0] abs1, abs2, step_rem, step_quo, q_fin, r_fin;
  logic [DW:0]   shifted, diff;

  assign req = req_t'(es_to_div_bus);

  // Operand magnitudes at acceptance; raw values for unsigned requests.
  always_comb begin
    abs1 = (!req.is_unsigned && req.src1[DW-1]) ? -req.src1 : req.src1;
    abs2 = (!req.is_unsigned && req.src2[DW-1]) ? -req.src2 : req.src2;
  end

  // One restoring step plus sign fix-up of the would-be final values.
  always_comb begin
    shifted = {rem, quo[DW-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[DW]) begin
      step_rem = diff[DW-1:0];
      step_quo = {quo[DW-2:0], 1'b1};
    end else begin
      step_rem = shifted[DW-1:0];
      step_quo = {quo[DW-2:0], 1'b0};
    end
    q_fin = qneg ? -step_quo : step_quo;
    r_fin = rneg ? -step_rem : step_rem;
  end

  // Next-state and datapath update; flush wins over everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    quo_n   = quo;
    dvs_n   = dvs;
    res_n   = res;
    mod_n   = mod_q;
    qneg_n  = qneg;
    rneg_n  = rneg;
    ok_n    = 1'b0;
    if (flush_ES) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            mod_n  = req.use_mod;
            qneg_n = !req.is_unsigned && (req.src1[DW-1] ^ req.src2[DW-1]);
            rneg_n = !req.is_unsigned && req.src1[DW-1];
            rem_n  = '0;
            quo_n  = abs1;
            dvs_n  = abs2;
            if (req.src2 == '0) begin
              // Divide by zero completes immediately with fixed results.
              state_n = DONE;
              ok_n    = 1'b1;
              cnt_n   = '0;
              res_n   = req.use_mod ? req.src1 : '1;
            end else begin
              state_n = BUSY;
              cnt_n   = CW'(DW - 1);
            end
          end
        end
        BUSY: begin
          if (!req.req_valid) begin
            state_n = IDLE;
          end else begin
            rem_n = step_rem;
            quo_n = step_quo;
            cnt_n = cnt - CW'(1);
            if (cnt == '0) begin
              state_n = DONE;
              ok_n    = 1'b1;
              res_n   = mod_q ? r_fin : q_fin;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      res   <= '0;
      mod_q <= 1'b0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      ok    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      quo   <= quo_n;
      dvs   <= dvs_n;
      res   <= res_n;
      mod_q <= mod_n;
      qneg  <= qneg_n;
      rneg  <= rneg_n;
      ok    <= ok_n;
    end
  end

  // Response bus is driven purely from registers.
  assign rsp.result    = res;
  assign rsp.ok        = ok;
  assign div_to_es_bus = rsp;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, results, flush/abort/reset behaviour.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic [66:0] bus;
  logic        flush;
  logic [32:0] rsp;

  int checks = 0;
  int errors = 0;

  div_iter dut (
    .clk          (clk),
    .resetn       (resetn),
    .es_to_div_bus(bus),
    .flush_ES     (flush),
    .div_to_es_bus(rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mod;
    logic        uns;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Issue one request, scramble operands after acceptance, wait for div_ok.
  task automatic do_div(input logic mod, input logic uns, input logic [31:0] s1,
                        input logic [31:0] s2, output logic [31:0] res, output int lat);
    bus = {1'b1, mod, uns, s1, s2};
    @(posedge clk); #1;
    bus = {1'b1, mod, uns, 32'h5A5A_1234, 32'h0000_0003};
    lat = 0;
    while (rsp[0] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = rsp[32:1];
    bus = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus    = '0;
    flush  = 1'b0;
    #3;
    checks++;
    if (rsp !== 33'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", rsp, 33'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp !== 33'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", rsp, 33'h0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t v[10];
    logic [31:0] res;
    int lat;
    v[0] = '{"u100div7",   1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       32};
    v[1] = '{"u100mod7",   1'b1, 1'b1, 32'd100,      32'd7,        32'd2,        32};
    v[2] = '{"sm7div2",    1'b0, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32};
    v[3] = '{"sm7mod2",    1'b1, 1'b0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32};
    v[4] = '{"s_ovf_div",  1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32};
    v[5] = '{"s_ovf_mod",  1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32};
    v[6] = '{"u_max_div1", 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32};
    v[7] = '{"u5div0",     1'b0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    v[8] = '{"u5mod0",     1'b1, 1'b1, 32'd5,        32'd0,        32'd5,        0};
    v[9] = '{"u_fff9div2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 32};
    for (int i = 0; i < 10; i++) begin
      do_div(v[i].mod, v[i].uns, v[i].s1, v[i].s2, res, lat);
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL %s_result: got %h expected %h", v[i].name, res, v[i].exp);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp !== {v[i].exp, 1'b0}) begin
        errors++;
        $display("FAIL %s_hold: got %h expected %h", v[i].name, rsp, {v[i].exp, 1'b0});
      end
    end
  endtask

  task automatic test_signed_zero_and_neg();
    logic [31:0] res;
    int lat;
    do_div(1'b1, 1'b0, 32'hFFFFFFFB, 32'h0, res, lat);
    checks++;
    if (res !== 32'hFFFFFFFB || lat != 0) begin
      errors++;
      $display("FAIL s_m5mod0: got %h/%0d expected %h/%0d", res, lat, 32'hFFFFFFFB, 0);
    end
    @(posedge clk); #1;
    do_div(1'b0, 1'b0, 32'd7, 32'hFFFFFFFE, res, lat);
    checks++;
    if (res !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL s7divm2: got %h expected %h", res, 32'hFFFFFFFD);
    end
    @(posedge clk); #1;
    do_div(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, res, lat);
    checks++;
    if (res !== 32'h1) begin
      errors++;
      $display("FAIL s7modm2: got %h expected %h", res, 32'h1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int k;
    bus = {1'b1, 1'b0, 1'b1, 32'd100, 32'd7};
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (rsp[0] !== 1'b1 && k < 40);
    checks++;
    if (rsp[32:1] !== 32'd14) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", rsp[32:1], 32'd14);
    end
    bus = {1'b1, 1'b0, 1'b1, 32'd9, 32'd2};
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (rsp[0] !== 1'b1 && k < 50);
    bus = '0;
    checks++;
    if (k != 34) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected %0d", k, 34);
    end
    checks++;
    if (rsp[32:1] !== 32'd4) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", rsp[32:1], 32'd4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int k;
    bus = {1'b1, 1'b0, 1'b1, 32'd100, 32'd7};
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    bus   = {1'b1, 1'b0, 1'b1, 32'd1000, 32'd10};
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (rsp[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_ok: got %b expected %b", rsp[0], 1'b0);
    end
    k = 0;
    while (rsp[0] !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    bus = '0;
    checks++;
    if (k != 33) begin
      errors++;
      $display("FAIL flush_next_latency: got %0d expected %0d", k, 33);
    end
    checks++;
    if (rsp[32:1] !== 32'd100) begin
      errors++;
      $display("FAIL flush_next_result: got %h expected %h", rsp[32:1], 32'd100);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_idle();
    bus   = {1'b1, 1'b0, 1'b1, 32'd5, 32'd0};
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus   = '0;
    checks++;
    if (rsp !== {32'd100, 1'b0}) begin
      errors++;
      $display("FAIL flush_priority: got %h expected %h", rsp, {32'd100, 1'b0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int seen;
    bus = {1'b1, 1'b1, 1'b1, 32'd100, 32'd7};
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    bus  = {1'b0, 1'b1, 1'b1, 32'd100, 32'd7};
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp[0] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_ok: got %0d expected %0d", seen, 0);
    end
    checks++;
    if (rsp[32:1] !== 32'd100) begin
      errors++;
      $display("FAIL abort_result_held: got %h expected %h", rsp[32:1], 32'd100);
    end
    bus = '0;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    int lat;
    bus = {1'b1, 1'b0, 1'b1, 32'd100, 32'd7};
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (rsp !== 33'h0) begin
      errors++;
      $display("FAIL reset_mid_busy: got %h expected %h", rsp, 33'h0);
    end
    bus = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    do_div(1'b0, 1'b1, 32'd100, 32'd7, res, lat);
    checks++;
    if (lat != 32 || res !== 32'd14) begin
      errors++;
      $display("FAIL after_reset_div: got %h/%0d expected %h/%0d", res, lat, 32'd14, 32);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_signed_zero_and_neg();
    test_back_to_back();
    test_flush();
    test_flush_idle();
    test_abort();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
